// File: rtl/alu_seq_nw.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_nw
// Purpose  : Registered N-bit ALU with single-cycle logic/arith/shift ops and
//            an iterative shift-add multiplier, behind a Start/Busy/Done
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_nw #(
    parameter int WIDTH = 24,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BInvert,
    input  logic             CIN,
    input  logic [2:0]       Operation,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             COUT,
    output logic             Overflow,
    output logic             Zero
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_xor = 3'b011;
    localparam logic [2:0] c_op_sll = 3'b100;
    localparam logic [2:0] c_op_slt = 3'b101;
    localparam logic [2:0] c_op_mul = 3'b110;
    localparam logic [2:0] c_op_srl = 3'b111;

    localparam logic [CW-1:0] c_cnt_init = CW'(WIDTH);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [SHW:0]  c_width_ext = (SHW + 1)'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_done;
    logic             r_busy;
    logic             r_ready;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_mb;
    logic [WIDTH:0]   w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt_ovf;
    logic             w_less;
    logic             w_shamt_big;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_next;

    // Operand conditioning and arithmetic datapath shared by the single-cycle ops.
    assign w_mb      = BInvert ? ~B : B;
    assign w_sum     = {1'b0, A} + {1'b0, w_mb} + {{WIDTH{1'b0}}, CIN};
    assign w_add_ovf = (A[WIDTH-1] == w_mb[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

    // SLT always subtracts raw B, independent of BInvert/CIN.
    assign w_diff    = A + ~B + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_slt_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
    assign w_less    = w_diff[WIDTH-1] ^ w_slt_ovf;

    // Shift amounts at or beyond WIDTH, including any high B bit, flush to zero.
    assign w_shamt_big = (|B[WIDTH-1:SHW]) || ({1'b0, B[SHW-1:0]} >= c_width_ext);

    // One multiplier step: conditionally accumulate the shifted multiplicand.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Single-cycle result and flag selection; MUL results come from the iterator.
    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (Operation)
            c_op_and: w_res = A & w_mb;
            c_op_or:  w_res = A | w_mb;
            c_op_xor: w_res = A ^ w_mb;
            c_op_add: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = w_add_ovf;
            end
            c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_less};
            c_op_sll: w_res = w_shamt_big ? '0 : (A << B[SHW-1:0]);
            c_op_srl: w_res = w_shamt_big ? '0 : (A >> B[SHW-1:0]);
            default:  w_res = '0;
        endcase
    end

    // Control FSM with registered handshake outputs and result/flag registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        if (Operation == c_op_mul) begin
                            r_state  <= S_MUL;
                            r_busy   <= 1'b1;
                            r_ready  <= 1'b0;
                            r_acc    <= '0;
                            r_mcand  <= A;
                            r_mplier <= B;
                            r_count  <= c_cnt_init;
                        end else begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_res;
                            r_cout   <= w_cout;
                            r_ovf    <= w_ovf;
                            r_zero   <= (w_res == '0);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - c_cnt_one;
                    if (r_count == c_cnt_one) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b1;
                        r_result <= w_acc_next;
                        r_cout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_zero   <= (w_acc_next == '0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign Ready    = r_ready;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Result   = r_result;
    assign COUT     = r_cout;
    assign Overflow = r_ovf;
    assign Zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_nw.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_nw
// Purpose  : Directed plus randomized checks of alu_seq_nw against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_nw;

    localparam int     W    = 24;
    localparam longint MASK = 64'h0000_0000_00FF_FFFF;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BInvert;
    logic         CIN;
    logic [2:0]   Operation;
    logic         Ready;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         COUT;
    logic         Overflow;
    logic         Zero;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t last;

    alu_seq_nw #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .BInvert   (BInvert),
        .CIN       (CIN),
        .Operation (Operation),
        .Ready     (Ready),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .COUT      (COUT),
        .Overflow  (Overflow),
        .Zero      (Zero)
    );

    initial forever #5 Clock = ~Clock;

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic binv,
                                   input logic cin);
        exp_t   e;
        longint ua, ub, um, sa, sb, sm, s, ss;
        e  = '0;
        ua = longint'(a);
        ub = longint'(b);
        um = binv ? (ub ^ MASK) : ub;
        sa = (ua > 64'h7F_FFFF) ? ua - (MASK + 1) : ua;
        sb = (ub > 64'h7F_FFFF) ? ub - (MASK + 1) : ub;
        sm = (um > 64'h7F_FFFF) ? um - (MASK + 1) : um;
        case (op)
            3'b000: e.res = W'(ua & um);
            3'b001: e.res = W'(ua | um);
            3'b011: e.res = W'(ua ^ um);
            3'b010: begin
                s      = ua + um + longint'(cin);
                ss     = sa + sm + longint'(cin);
                e.res  = W'(s & MASK);
                e.cout = (s > MASK);
                e.ovf  = (ss > 64'sd8388607) || (ss < -64'sd8388608);
            end
            3'b101: e.res = (sa < sb) ? 24'd1 : 24'd0;
            3'b100: e.res = (ub >= W) ? 24'd0 : W'((ua << ub) & MASK);
            3'b111: e.res = (ub >= W) ? 24'd0 : W'(ua >> ub);
            default: e.res = W'((ua * ub) & MASK);
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input logic c,
                             input logic o, input logic dn, input logic bz);
        check({tag, ".res"},   64'(Result),   64'(r));
        check({tag, ".cout"},  64'(COUT),     64'(c));
        check({tag, ".ovf"},   64'(Overflow), 64'(o));
        check({tag, ".zero"},  64'(Zero),     64'(r == '0));
        check({tag, ".done"},  64'(Done),     64'(dn));
        check({tag, ".busy"},  64'(Busy),     64'(bz));
        check({tag, ".ready"}, 64'(Ready),    64'(!bz));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic binv, input logic cin);
        Operation = op;
        A         = a;
        B         = b;
        BInvert   = binv;
        CIN       = cin;
        Start     = 1'b1;
    endtask

    // Single-cycle op: Done and the result appear after exactly one edge.
    task automatic run_single(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic binv, input logic cin);
        exp_t e;
        drive(op, a, b, binv, cin);
        tick();
        Start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        e     = model(op, a, b, binv, cin);
        check_out(tag, e.res, e.cout, e.ovf, 1'b1, 1'b0);
        last = e;
    endtask

    // Multiply: Busy for W cycles with the old result held, Done at cycle W+1.
    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic noise);
        exp_t e;
        drive(3'b110, a, b, 1'b0, 1'b0);
        tick();
        for (int c = 1; c <= W; c++) begin
            if (noise && c < W) begin
                Operation = 3'($urandom_range(0, 7));
                A         = W'($urandom);
                B         = W'($urandom);
                Start     = 1'($urandom);
            end else begin
                Start = 1'b0;
            end
            check_out({tag, ".busy"}, last.res, last.cout, last.ovf, 1'b0, 1'b1);
            tick();
        end
        Start = 1'b0;
        e     = model(3'b110, a, b, 1'b0, 1'b0);
        check_out({tag, ".done"}, e.res, e.cout, e.ovf, 1'b1, 1'b0);
        last = e;
    endtask

    // One idle cycle: Done drops, result and flags held.
    task automatic idle_check(input string tag);
        Start = 1'b0;
        tick();
        check_out(tag, last.res, last.cout, last.ovf, 1'b0, 1'b0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 24'hFF_FFFF;
            2:       return 24'h7F_FFFF;
            3:       return 24'h80_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [2:0]   op;
        logic [W-1:0] ra, rb;

        Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        BInvert = 1'b0; CIN = 1'b0; Operation = 3'b000;
        last = '0;
        tick();
        tick();
        Reset = 1'b0;
        check_out("reset", 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed vectors.
        run_single("add_wrap", 3'b010, 24'hFF_FFFF, 24'h00_0001, 1'b0, 1'b0);
        check("add_wrap.lit", 64'({COUT, Zero, Result}), 64'({1'b1, 1'b1, 24'h0}));
        idle_check("idle1");
        run_single("sub", 3'b010, 24'd5, 24'd7, 1'b1, 1'b1);
        check("sub.lit", 64'({COUT, Result}), 64'({1'b0, 24'hFF_FFFE}));
        run_single("add_ovf", 3'b010, 24'h7F_FFFF, 24'd1, 1'b0, 1'b0);
        check("add_ovf.lit", 64'({Overflow, Result}), 64'({1'b1, 24'h80_0000}));
        run_single("slt", 3'b101, 24'hFF_FFFF, 24'd1, 1'b1, 1'b0);
        check("slt.lit", 64'(Result), 64'd1);
        run_single("sll23", 3'b100, 24'd1, 24'd23, 1'b0, 1'b0);
        check("sll23.lit", 64'(Result), 64'h80_0000);
        run_single("sll24", 3'b100, 24'd1, 24'd24, 1'b0, 1'b0);
        run_single("sllhi", 3'b100, 24'd1, 24'h00_0101, 1'b0, 1'b0);
        run_single("srl23", 3'b111, 24'h80_0000, 24'd23, 1'b0, 1'b0);
        check("srl23.lit", 64'(Result), 64'd1);
        idle_check("idle2");

        run_mul("mul", 24'h00_0123, 24'h00_0045, 1'b1);
        check("mul.lit", 64'(Result), 64'h4E6F);
        idle_check("idle3");
        run_mul("mulwrap", 24'h00_1000, 24'h00_1000, 1'b0);
        check("mulwrap.lit", 64'({Zero, Result}), 64'({1'b1, 24'h0}));
        idle_check("idle4");

        // Reset in cycle 10 of a multiply aborts it with no Done.
        drive(3'b110, 24'h00_0123, 24'h00_0045, 1'b0, 1'b0);
        tick();
        Start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        last = '0;
        check_out("mulrst", 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < W + 4; c++) begin
            tick();
            check("mulrst.nodone", 64'(Done), 64'd0);
        end

        // Back-to-back single-cycle ops give Done on consecutive cycles.
        run_single("b2b_add", 3'b010, 24'd2, 24'd3, 1'b0, 1'b0);
        check("b2b_add.lit", 64'(Result), 64'd5);
        run_single("b2b_xor", 3'b011, 24'h0000FF, 24'h00000F, 1'b0, 1'b0);
        check("b2b_xor.lit", 64'(Result), 64'hF0);
        idle_check("idle5");

        // Randomized mix against the reference model.
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = rand_opnd();
            rb = ($urandom_range(0, 3) == 0) ? rand_opnd() : W'($urandom_range(0, 30));
            if (op == 3'b110)
                run_mul("rmul", ra, rb, 1'($urandom));
            else
                run_single("rop", op, ra, rb, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_check("ridle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_nw.md
Name: alu_seq_nw

Overview:
- Parametrised, registered N-bit ALU; next generation of the 1-bit ALU slice.
- Single-cycle ops: AND, OR, ADD/SUB, XOR, SLL, SLT, SRL.
- Iterative shift-add multiplier taking WIDTH cycles.
- Start/Busy/Done handshake; sits between register file read and writeback in the 24-bit CPU datapath.

Parameters:
- WIDTH, 24, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount field width taken from B.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  accept operands/op this cycle when Ready=1.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- BInvert  input  1  invert B before ADD/SUB/AND/OR/XOR.
- CIN  input  1  carry-in for ADD/SUB.
- Operation  input  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 SLL, 101 SLT, 110 MUL, 111 SRL.
- Ready  output  1  block can accept Start.
- Busy  output  1  operation in progress (multiply iterating).
- Done  output  1  one-cycle pulse: Result/flags valid.
- Result  output  WIDTH  registered result, held until next accepted Start.
- COUT  output  1  carry-out of ADD/SUB, else 0.
- Overflow  output  1  signed overflow of ADD/SUB, else 0.
- Zero  output  1  Result==0, registered with Result.

Behaviour:
- Reset (synchronous, active-high, priority over everything, including mid-multiply):
  - state=IDLE.
  - Result=0, COUT=0, Overflow=0, Zero=1, Done=0, Busy=0, Ready=1.
- States: IDLE, MUL, DONE.
- Ready = (state != MUL); Busy = (state == MUL).
- Start while Ready=0 is ignored; no queuing.
- Accepted Start latches A, B, BInvert, CIN, Operation. Inputs may change afterwards without effect.
- Operand B: mB = BInvert ? ~B : B, used by AND/OR/ADD/XOR.
- Single-cycle ops: IDLE/DONE --Start--> DONE. Result/flags registered at that edge; Done=1 the following cycle (latency 1).
- ADD:
  - {COUT,Result} = A + mB + CIN, (WIDTH+1)-bit sum.
  - Overflow = (A[W-1]==mB[W-1]) && (Result[W-1]!=A[W-1]).
  - Subtract = BInvert=1, CIN=1.
- SLT:
  - Always computes A - B internally; BInvert and CIN are ignored.
  - Result = {0…, sign XOR overflow} (signed less-than).
  - COUT=0, Overflow=0.
- SLL: Result = A << B[SHW-1:0]. Any set bit of B above SHW-1, or shift amount >= WIDTH, gives Result=0.
- SRL: logical right shift; same amount rules as SLL.
- AND, OR, XOR: bitwise A op mB; COUT=0, Overflow=0.
- MUL (unsigned; BInvert and CIN ignored):
  - Accepted Start: IDLE/DONE -> MUL. acc=0, mcand=A, mplier=B, count=WIDTH.
  - Each MUL cycle: if mplier[0], acc += mcand (WIDTH-bit, wraps); mcand <<= 1; mplier >>= 1; count -= 1.
  - When count reaches 0: -> DONE with Result=acc (low WIDTH bits of A*B), COUT=0, Overflow=0.
  - Done asserted exactly WIDTH+1 cycles after the Start cycle.
- DONE:
  - Done=1 for one cycle; then -> IDLE unless Start is accepted in the same cycle.
  - Back-to-back Start in DONE is accepted; Done pulses again next cycle (single-cycle op) or after WIDTH+1 (MUL).
- Zero is recomputed only when Result is updated.
- Result and flags are stable between Done pulses.
- Reset during MUL: abort, outputs take reset values; no Done.

Test Plan:
- ADD wrap: A=0xFFFFFF, B=0x000001, BInvert=0, CIN=0, Op=010 -> next cycle Done=1, Result=0x000000, COUT=1, Zero=1, Overflow=0.
- SUB and overflow:
  - A=5, B=7, BInvert=1, CIN=1, Op=010 -> Result=0xFFFFFE, COUT=0.
  - A=0x7FFFFF, B=1, ADD -> Result=0x800000, Overflow=1.
- SLT/shifts:
  - A=0xFFFFFF, B=0x000001, Op=101 -> Result=1.
  - A=0x000001, B=23, Op=100 -> 0x800000.
  - B=24, Op=100 -> 0.
  - A=0x800000, B=23, Op=111 -> 0x000001.
- MUL timing:
  - A=0x000123, B=0x000045, Op=110 -> Busy=1 and Ready=0 for 24 cycles, Done at cycle 25 after Start, Result=0x004E6F.
  - Start pulses during Busy are ignored and leave Result unchanged.
- MUL wrap: A=0x001000, B=0x001000 -> Result=0x000000, Zero=1 (low 24 bits of 0x1000000).
- Reset/back-to-back:
  - Reset asserted at cycle 10 of a MUL -> next cycle state IDLE, Result=0, Zero=1, no Done.
  - Then Start(ADD 2+3) in IDLE, followed by Start(XOR 0xFF^0x0F) in the DONE cycle -> Done on two consecutive cycles, Result=5 then 0xF0.
